// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: samples VGA sync/blank, measures line/frame totals, rebuilds x/y/de, locks.
// Define VGA_MON_ACTIVE_CHECK_EN to also check the active width and height.
module vga_timing_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter bit HSYNC_NEG   = 1'b1,
    parameter bit VSYNC_NEG   = 1'b1,
    parameter int CW          = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          hblank,
    input  logic          vblank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          frame_start,
    output logic [CW-1:0] h_total_meas,
    output logic [CW-1:0] v_total_meas,
    output logic          locked,
    output logic          mismatch
);
    localparam logic [CW-1:0] CMAX  = '1;
    localparam logic [CW-1:0] H_TOT = CW'(H_TOTAL);
    localparam logic [CW-1:0] V_TOT = CW'(V_TOTAL);
    localparam logic [CW-1:0] L_FRM = CW'(LOCK_FRAMES);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
    state_t state;

    logic hs1, hs2, vs1, vs2, hb1, hb2, vb1, vb2;
    logic [CW-1:0] hcnt, vcnt, good_cnt;
    logic h_seen, v_seen, lines_ok;

    // Syncs are polarity-corrected at the input so 1 always means asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {hs1, vs1, hb1, vb1} <= '0;
            {hs2, vs2, hb2, vb2} <= '0;
        end else begin
            hs1 <= hsync ^ HSYNC_NEG;
            vs1 <= vsync ^ VSYNC_NEG;
            hb1 <= hblank;
            vb1 <= vblank;
            {hs2, vs2, hb2, vb2} <= {hs1, vs1, hb1, vb1};
        end
    end

    logic h_lead, v_lead, hb_fall, vb_fall;
    assign h_lead  = hs1 & ~hs2;
    assign v_lead  = vs1 & ~vs2;
    assign hb_fall = ~hb1 & hb2;
    assign vb_fall = ~vb1 & vb2;

    logic [CW-1:0] h_next, v_next;
    assign h_next = (hcnt == CMAX) ? CMAX : hcnt + CW'(1);
    assign v_next = (h_lead && vcnt != CMAX) ? vcnt + CW'(1) : vcnt;

    logic h_act_good, v_act_good;
`ifdef VGA_MON_ACTIVE_CHECK_EN
    logic hb_rise, vb_rise, h_act_ok, v_act_ok;
    assign hb_rise = hb1 & ~hb2;
    assign vb_rise = vb1 & ~vb2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_act_ok <= 1'b0;
            v_act_ok <= 1'b0;
        end else begin
            if (hb_rise)
                h_act_ok <= ({1'b0, x} + 1'b1) == (CW + 1)'(H_ACTIVE);
            if (vb_rise)
                v_act_ok <= ({1'b0, y} + 1'b1) == (CW + 1)'(V_ACTIVE);
        end
    end
    assign h_act_good = h_act_ok;
    assign v_act_good = v_act_ok;
`else
    // Active size is not checked in this build
    assign h_act_good = (H_ACTIVE >= 0);
    assign v_act_good = (V_ACTIVE >= 0);
`endif

    logic line_chk, line_ok, frame_chk, frame_ok, line_bad, fail;
    assign line_chk  = h_lead & h_seen;
    assign line_ok   = (h_next == H_TOT) & (hcnt != CMAX) & h_act_good;
    assign line_bad  = line_chk & ~line_ok;
    assign frame_chk = v_lead & v_seen;
    assign frame_ok  = lines_ok & ~line_bad & (v_next == V_TOT) & v_act_good;
    assign fail      = line_bad | (frame_chk & ~frame_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt         <= '0;
            vcnt         <= '0;
            h_seen       <= 1'b0;
            v_seen       <= 1'b0;
            lines_ok     <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            frame_start  <= 1'b0;
        end else begin
            hcnt        <= h_lead ? '0 : h_next;
            vcnt        <= v_lead ? '0 : v_next;
            frame_start <= v_lead;
            if (h_lead)
                h_seen <= 1'b1;
            if (v_lead)
                v_seen <= 1'b1;
            if (line_chk)
                h_total_meas <= h_next;
            if (frame_chk)
                v_total_meas <= v_next;
            if (v_lead)
                lines_ok <= 1'b1;
            else if (line_bad)
                lines_ok <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x  <= '0;
            y  <= '0;
            de <= 1'b0;
        end else begin
            de <= ~hb1 & ~vb1;
            if (hb_fall)
                x <= '0;
            else if (!hb1 && x != CMAX)
                x <= x + CW'(1);
            if (vb_fall)
                y <= '0;
            else if (hb_fall && !vb1 && y != CMAX)
                y <= y + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            locked   <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            unique case (state)
                UNLOCKED: begin
                    good_cnt <= '0;
                    if (v_seen)
                        state <= ACQUIRE;
                end
                ACQUIRE: begin
                    if (fail) begin
                        state    <= UNLOCKED;
                        good_cnt <= '0;
                        mismatch <= 1'b1;
                    end else if (frame_chk) begin
                        good_cnt <= good_cnt + CW'(1);
                        if (good_cnt + CW'(1) == L_FRM) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (fail) begin
                        state    <= UNLOCKED;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                        mismatch <= 1'b1;
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed checks of vga_timing_monitor on a small
// 40x12 mode (32x8 active), scaled from 640x480 to keep runs short.
module tb_vga_timing_monitor;
    localparam int HA = 32;
    localparam int HT = 40;
    localparam int VA = 8;
    localparam int VT = 12;
    localparam int CW = 12;
    localparam int HS_START = 34;
    localparam int HS_END = 38;
    localparam int VS_LINE = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hsync = 1'b1, vsync = 1'b1, hblank = 1'b1, vblank = 1'b1;
    logic [CW-1:0] x, y, h_total_meas, v_total_meas;
    logic de, frame_start, locked, mismatch;

    int checks = 0;
    int fails = 0;
    int gh = 0, gv = 0, act_w = HA;
    bit stretch = 1'b0, hs_hold = 1'b0;

    always #5 clk = ~clk;

    vga_timing_monitor #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .HSYNC_NEG(1'b1), .VSYNC_NEG(1'b1), .CW(CW), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .x(x), .y(y), .de(de),
        .frame_start(frame_start), .h_total_meas(h_total_meas),
        .v_total_meas(v_total_meas), .locked(locked), .mismatch(mismatch)
    );

    task automatic drive();
        hblank = (gh >= act_w);
        vblank = (gv >= VA);
        hsync  = hs_hold ? 1'b1 : !(gh >= HS_START && gh < HS_END);
        vsync  = !(gv == VS_LINE);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (gh >= (stretch ? HT : HT - 1)) begin
            gh = 0;
            stretch = 1'b0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else begin
            gh++;
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gh = 0;
        gv = 0;
        stretch = 1'b0;
        hs_hold = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic tick_until_gh(input int target);
        int n = 0;
        do begin
            tick();
            n++;
        end while (gh != target && n < 200);
        checks++;
        if (gh != target) begin
            fails++;
            $display("FAIL gen_wait: gh=%0d want %0d", gh, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (x !== '0) begin fails++; $display("FAIL reset_x: got %0d want 0", x); end
        checks++; if (y !== '0) begin fails++; $display("FAIL reset_y: got %0d want 0", y); end
        checks++; if (de !== 1'b0) begin fails++; $display("FAIL reset_de: got %0b want 0", de); end
        checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs: got %0b want 0", frame_start); end
        checks++; if (h_total_meas !== '0) begin fails++; $display("FAIL reset_hmeas: got %0d want 0", h_total_meas); end
        checks++; if (v_total_meas !== '0) begin fails++; $display("FAIL reset_vmeas: got %0d want 0", v_total_meas); end
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0b want 0", locked); end
        checks++; if (mismatch !== 1'b0) begin fails++; $display("FAIL reset_mismatch: got %0b want 0", mismatch); end
    endtask

    // 3rd vsync leading edge is driven at n=1320; lock shows 2 clks later
    task automatic test_lock();
        do_reset();
        repeat (1321) tick();
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_early: got %0b want 0", locked); end
        tick();
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_edge: got %0b want 1", locked); end
        checks++; if (h_total_meas !== CW'(HT)) begin fails++; $display("FAIL lock_hmeas: got %0d want %0d", h_total_meas, HT); end
        checks++; if (v_total_meas !== CW'(VT)) begin fails++; $display("FAIL lock_vmeas: got %0d want %0d", v_total_meas, VT); end
    endtask

    task automatic test_active();
        int n = 0, idx = 0, err = 0, fs = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 600);
        checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL act_fs_wait: got %0b want 1", frame_start); end
        repeat (HT * VT) begin
            tick();
            if (frame_start === 1'b1) fs++;
            if (de === 1'b1) begin
                if (x !== CW'(idx % HA) || y !== CW'(idx / HA)) err++;
                idx++;
            end
        end
        checks++; if (idx != HA * VA) begin fails++; $display("FAIL act_de_count: got %0d want %0d", idx, HA * VA); end
        checks++; if (err != 0) begin fails++; $display("FAIL act_xy: %0d bad pixels want 0", err); end
        checks++; if (fs != 1) begin fails++; $display("FAIL act_fs_count: got %0d want 1", fs); end
    endtask

    task automatic test_stretch();
        int n = 0, mis = 0;
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL str_pre_lock: got %0b want 1", locked); end
        stretch = 1'b1;
        do begin
            tick();
            n++;
        end while (mismatch !== 1'b1 && n < 200);
        checks++; if (mismatch !== 1'b1) begin fails++; $display("FAIL str_mismatch: got %0b want 1", mismatch); end
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL str_unlock: got %0b want 0", locked); end
        tick();
        checks++; if (mismatch !== 1'b0) begin fails++; $display("FAIL str_pulse: got %0b want 0", mismatch); end
        n = 1;
        while (locked !== 1'b1 && n < 2000) begin
            tick();
            n++;
            if (mismatch === 1'b1) mis++;
        end
        checks++; if (n <= 2 * HT * VT || n > 3 * HT * VT) begin fails++; $display("FAIL str_relock: got %0d clks want 961..1440", n); end
        checks++; if (mis != 1) begin fails++; $display("FAIL str_frame_mis: got %0d want 1", mis); end
    endtask

    task automatic test_reset_mid();
        tick_until_gh(10);
        #4 reset = 1'b1;
        #1;
        checks++;
        if ({x, y, de, frame_start, h_total_meas, v_total_meas, locked, mismatch} !== '0) begin
            fails++;
            $display("FAIL mid_async: x=%0d y=%0d de=%0b hm=%0d vm=%0d lk=%0b want all 0",
                     x, y, de, h_total_meas, v_total_meas, locked);
        end
        repeat (3) tick();
        reset = 1'b0;
        tick_until_gh(HS_START);
        repeat (2) tick();
        checks++; if (h_total_meas !== '0) begin fails++; $display("FAIL mid_first_line: got %0d want 0", h_total_meas); end
        tick_until_gh(HS_START);
        tick();
        checks++; if (h_total_meas !== '0) begin fails++; $display("FAIL mid_pre_latch: got %0d want 0", h_total_meas); end
        tick();
        checks++; if (h_total_meas !== CW'(HT)) begin fails++; $display("FAIL mid_latch: got %0d want %0d", h_total_meas, HT); end
        checks++; if (v_total_meas !== '0) begin fails++; $display("FAIL mid_vmeas: got %0d want 0", v_total_meas); end
    endtask

    task automatic test_saturate();
        tick_until_gh(0);
        hs_hold = 1'b1;
        repeat (5000) tick();
        tick_until_gh(0);
        checks++; if (h_total_meas !== CW'(HT)) begin fails++; $display("FAIL sat_hold: got %0d want %0d", h_total_meas, HT); end
        hs_hold = 1'b0;
        tick_until_gh(HS_START);
        repeat (2) tick();
        checks++; if (h_total_meas !== 12'd4095) begin fails++; $display("FAIL sat_hmeas: got %0d want 4095", h_total_meas); end
        checks++; if (mismatch !== 1'b1) begin fails++; $display("FAIL sat_mismatch: got %0b want 1", mismatch); end
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL sat_locked: got %0b want 0", locked); end
    endtask

    task automatic test_active_width();
        bit exp_locked;
        int mis = 0;
`ifdef VGA_MON_ACTIVE_CHECK_EN
        exp_locked = 1'b0;
`else
        exp_locked = 1'b1;
`endif
        act_w = HA - 1;
        do_reset();
        repeat (1500) begin
            tick();
            if (mismatch === 1'b1) mis++;
        end
        checks++; if (locked !== exp_locked) begin fails++; $display("FAIL aw_locked: got %0b want %0b", locked, exp_locked); end
        checks++; if (exp_locked ? (mis != 0) : (mis == 0)) begin fails++; $display("FAIL aw_mismatch: got %0d pulses, want none=%0b", mis, exp_locked); end
        checks++; if (h_total_meas !== CW'(HT)) begin fails++; $display("FAIL aw_hmeas: got %0d want %0d", h_total_meas, HT); end
        act_w = HA;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_active();
        test_stretch();
        test_reset_mid();
        test_saturate();
        test_active_width();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
